topic_tracker: RTL and testbench

Parametrised successor to the single-window topic voter. Accumulates per-theta episode winners over a delta window, then runs a sequential argmax scan at each `delta_tick` and commits a stability-gated topic winner. Sits between the episode memory (theta-rate winners) and the downstream long-term bias logic. New features:
- configurable pattern count and vote width
- optional leaky vote carry-over between windows
- change pulse
- busy/overrun signalling

---
 rtl/topic_pkg.sv | 17 +
 rtl/topic_tracker_if.sv | 28 ++
 rtl/topic_tracker_sat_vote_bank.sv | 54 +++++
 rtl/topic_tracker.sv | 168 ++++++++++++++++
 tb/tb_topic_tracker.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/topic_pkg.sv
// Shared types and defaults for the topic tracker slice.
package topic_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam int unsigned DECAY_CLEAR = 0;
    localparam int unsigned DECAY_HALVE = 1;

    localparam int unsigned DEF_N_PAT  = 6;
    localparam int unsigned DEF_PAT_W  = 3;
    localparam int unsigned DEF_VOTE_W = 3;

endpackage

// File: rtl/topic_tracker_if.sv
// Episode-memory side inputs and topic outputs of the tracker.
interface topic_tracker_if
    import topic_pkg::*;
#(
    parameter int unsigned PAT_W  = DEF_PAT_W,
    parameter int unsigned VOTE_W = DEF_VOTE_W
);
    logic              theta_tick;
    logic              delta_tick;
    logic              ep_valid;
    logic [PAT_W-1:0]  ep_winner;
    logic [PAT_W-1:0]  topic_winner;
    logic [VOTE_W-1:0] topic_strength;
    logic              topic_valid;
    logic              topic_changed;
    logic              busy;
    logic              overrun;

    modport master (
        output theta_tick, delta_tick, ep_valid, ep_winner,
        input  topic_winner, topic_strength, topic_valid, topic_changed, busy, overrun
    );

    modport slave (
        input  theta_tick, delta_tick, ep_valid, ep_winner,
        output topic_winner, topic_strength, topic_valid, topic_changed, busy, overrun
    );
endinterface

// File: rtl/topic_tracker_sat_vote_bank.sv
// Vote register file: per-entry saturating increment, clear/halve decay, read port.
module sat_vote_bank
    import topic_pkg::*;
#(
    parameter int unsigned N_PAT      = DEF_N_PAT,
    parameter int unsigned PAT_W      = DEF_PAT_W,
    parameter int unsigned VOTE_W     = DEF_VOTE_W,
    parameter int unsigned DECAY_MODE = DECAY_CLEAR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_en_i,
    input  logic [PAT_W-1:0]  inc_idx_i,
    input  logic              decay_en_i,
    input  logic [PAT_W-1:0]  rd_idx_i,
    output logic [VOTE_W-1:0] rd_val_o
);
    logic [VOTE_W-1:0] vote_q [N_PAT];
    logic [VOTE_W-1:0] vote_d [N_PAT];

    // Decay first, then apply the increment to the post-decay value.
    always_comb begin
        for (int unsigned i = 0; i < N_PAT; i++) begin
            vote_d[i] = vote_q[i];
            if (decay_en_i) begin
                vote_d[i] = (DECAY_MODE == DECAY_HALVE) ? (vote_q[i] >> 1) : '0;
            end
            if (inc_en_i && (inc_idx_i == PAT_W'(i)) && !(&vote_d[i])) begin
                vote_d[i] = vote_d[i] + VOTE_W'(1);
            end
        end
    end

    // Vote storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_PAT; i++) begin
                vote_q[i] <= '0;
            end
        end else begin
            vote_q <= vote_d;
        end
    end

    // Read mux for the sequential scan.
    always_comb begin
        rd_val_o = '0;
        for (int unsigned i = 0; i < N_PAT; i++) begin
            if (rd_idx_i == PAT_W'(i)) begin
                rd_val_o = vote_q[i];
            end
        end
    end
endmodule

// File: rtl/topic_tracker.sv
// Topic tracker: windowed vote accumulation, sequential argmax scan, gated commit.
module topic_tracker
    import topic_pkg::*;
#(
    parameter int unsigned N_PAT      = DEF_N_PAT,
    parameter int unsigned PAT_W      = DEF_PAT_W,
    parameter int unsigned VOTE_W     = DEF_VOTE_W,
    parameter int unsigned STAB_THR   = 3,
    parameter int unsigned DECAY_MODE = DECAY_CLEAR
) (
    input logic              clk,
    input logic              rst_n,
    topic_tracker_if.slave   bus
);
    state_e            state_q, state_d;
    logic [PAT_W-1:0]  scan_idx_q, scan_idx_d;
    logic [VOTE_W-1:0] max_val_q, max_val_d;
    logic [PAT_W-1:0]  max_idx_q, max_idx_d;
    logic              pend_v_q, pend_v_d;
    logic [PAT_W-1:0]  pend_idx_q, pend_idx_d;
    logic              overrun_q, overrun_d;
    logic [PAT_W-1:0]  winner_q, winner_d;
    logic [VOTE_W-1:0] strength_q, strength_d;
    logic              valid_q, valid_d;
    logic              changed_q, changed_d;
    logic              busy_q, busy_d;

    logic              vote_take;
    logic              inc_en;
    logic [PAT_W-1:0]  inc_idx;
    logic              decay_en;
    logic [VOTE_W-1:0] rd_val;

    assign vote_take = bus.theta_tick && bus.ep_valid && (32'(bus.ep_winner) < N_PAT);

    sat_vote_bank #(
        .N_PAT      (N_PAT),
        .PAT_W      (PAT_W),
        .VOTE_W     (VOTE_W),
        .DECAY_MODE (DECAY_MODE)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_en_i   (inc_en),
        .inc_idx_i  (inc_idx),
        .decay_en_i (decay_en),
        .rd_idx_i   (scan_idx_q),
        .rd_val_o   (rd_val)
    );

    // Next-state, scan datapath, busy-event handling and commit decisions.
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        max_val_d  = max_val_q;
        max_idx_d  = max_idx_q;
        pend_v_d   = pend_v_q;
        pend_idx_d = pend_idx_q;
        overrun_d  = overrun_q;
        winner_d   = winner_q;
        strength_d = strength_q;
        valid_d    = valid_q;
        changed_d  = 1'b0;
        inc_en     = 1'b0;
        inc_idx    = bus.ep_winner;
        decay_en   = 1'b0;
        case (state_q)
            ACCUM: begin
                inc_en = vote_take;
                if (bus.delta_tick) begin
                    state_d    = SCAN;
                    scan_idx_d = '0;
                    max_val_d  = '0;
                    max_idx_d  = '0;
                end
            end
            SCAN: begin
                if (rd_val > max_val_q) begin
                    max_val_d = rd_val;
                    max_idx_d = scan_idx_q;
                end
                if (scan_idx_q == PAT_W'(N_PAT - 1)) begin
                    state_d = COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + PAT_W'(1);
                end
                if (vote_take) begin
                    if (!pend_v_q) begin
                        pend_v_d   = 1'b1;
                        pend_idx_d = bus.ep_winner;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                if (bus.delta_tick) begin
                    overrun_d = 1'b1;
                end
            end
            COMMIT: begin
                strength_d = max_val_q;
                if (32'(max_val_q) >= STAB_THR) begin
                    winner_d  = max_idx_q;
                    valid_d   = 1'b1;
                    changed_d = (max_idx_q != winner_q) || !valid_q;
                end
                decay_en = 1'b1;
                // The pending slot is drained here, so a first vote arriving in
                // this cycle goes straight into the bank instead of the slot.
                if (pend_v_q) begin
                    inc_en  = 1'b1;
                    inc_idx = pend_idx_q;
                    if (vote_take) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    inc_en = vote_take;
                end
                pend_v_d = 1'b0;
                if (bus.delta_tick) begin
                    overrun_d = 1'b1;
                end
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
        busy_d = (state_d != ACCUM);
    end

    // Register FSM state, scan context, pending vote and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            scan_idx_q <= '0;
            max_val_q  <= '0;
            max_idx_q  <= '0;
            pend_v_q   <= 1'b0;
            pend_idx_q <= '0;
            overrun_q  <= 1'b0;
            winner_q   <= '0;
            strength_q <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
            pend_v_q   <= pend_v_d;
            pend_idx_q <= pend_idx_d;
            overrun_q  <= overrun_d;
            winner_q   <= winner_d;
            strength_q <= strength_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.topic_winner   = winner_q;
    assign bus.topic_strength = strength_q;
    assign bus.topic_valid    = valid_q;
    assign bus.topic_changed  = changed_q;
    assign bus.busy           = busy_q;
    assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_topic_tracker.sv
// Scoreboard bench for topic_tracker: clear-mode instance plus a leaky-mode instance.
module tb_topic_tracker;
    import topic_pkg::*;

    localparam int unsigned N  = 6;
    localparam int unsigned PW = 3;
    localparam int unsigned VW = 3;

    typedef struct packed {
        logic [PW-1:0] w;
        logic [VW-1:0] s;
        logic          v;
        logic          c;
        logic          o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    topic_tracker_if #(.PAT_W(PW), .VOTE_W(VW)) bus0 ();
    topic_tracker_if #(.PAT_W(PW), .VOTE_W(VW)) bus1 ();

    topic_tracker #(
        .N_PAT(N), .PAT_W(PW), .VOTE_W(VW), .STAB_THR(3), .DECAY_MODE(DECAY_CLEAR)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    topic_tracker #(
        .N_PAT(N), .PAT_W(PW), .VOTE_W(VW), .STAB_THR(3), .DECAY_MODE(DECAY_HALVE)
    ) u_leak (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    logic pb0 = 1'b0;
    logic pb1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_commit(input string tag, input exp_t e, input logic [PW-1:0] w,
                              input logic [VW-1:0] s, input logic v, input logic c, input logic o);
        chk({tag, " winner"},   32'(w), 32'(e.w));
        chk({tag, " strength"}, 32'(s), 32'(e.s));
        chk({tag, " valid"},    32'(v), 32'(e.v));
        chk({tag, " changed"},  32'(c), 32'(e.c));
        chk({tag, " overrun"},  32'(o), 32'(e.o));
    endtask

    // Monitor, clear-mode instance: a busy fall marks the cycle new topic values appear.
    always @(negedge clk) begin
        if (!rst_n) begin
            pb0 = 1'b0;
        end else begin
            if (pb0 && !bus0.busy) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0 commit: got unexpected commit required none");
                end else begin
                    cmp_commit("dut0", q0.pop_front(), bus0.topic_winner, bus0.topic_strength,
                               bus0.topic_valid, bus0.topic_changed, bus0.overrun);
                end
            end else if (bus0.topic_changed) begin
                checks++; errors++;
                $display("FAIL dut0 stray_change: got 1 required 0");
            end
            pb0 = bus0.busy;
        end
    end

    // Monitor, leaky-mode instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pb1 = 1'b0;
        end else begin
            if (pb1 && !bus1.busy) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1 commit: got unexpected commit required none");
                end else begin
                    cmp_commit("dut1", q1.pop_front(), bus1.topic_winner, bus1.topic_strength,
                               bus1.topic_valid, bus1.topic_changed, bus1.overrun);
                end
            end else if (bus1.topic_changed) begin
                checks++; errors++;
                $display("FAIL dut1 stray_change: got 1 required 0");
            end
            pb1 = bus1.busy;
        end
    end

    // One clock cycle of stimulus to the selected instance.
    task automatic cyc(input bit s, input bit th, input bit de, input bit v, input logic [PW-1:0] w);
        if (!s) begin
            bus0.theta_tick = th; bus0.delta_tick = de; bus0.ep_valid = v; bus0.ep_winner = w;
        end else begin
            bus1.theta_tick = th; bus1.delta_tick = de; bus1.ep_valid = v; bus1.ep_winner = w;
        end
        @(posedge clk);
        #1;
        if (!s) begin
            bus0.theta_tick = 1'b0; bus0.delta_tick = 1'b0; bus0.ep_valid = 1'b0; bus0.ep_winner = '0;
        end else begin
            bus1.theta_tick = 1'b0; bus1.delta_tick = 1'b0; bus1.ep_valid = 1'b0; bus1.ep_winner = '0;
        end
    endtask

    task automatic votes(input bit s, input logic [PW-1:0] w, input int n);
        repeat (n) cyc(s, 1'b1, 1'b0, 1'b1, w);
    endtask

    task automatic idle(input bit s, input int n);
        repeat (n) cyc(s, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic expect_drained(input bit s, input string name);
        checks++;
        if ((s ? q1.size() : q0.size()) != 0) begin
            errors++;
            $display("FAIL %s: got no commit within budget required commit", name);
            if (s) q1.delete(); else q0.delete();
        end
    endtask

    // Close a window (optionally with a same-cycle theta) and wait out scan/commit.
    task automatic close(input bit s, input bit th, input logic [PW-1:0] w, input exp_t e, input string name);
        if (s) q1.push_back(e); else q0.push_back(e);
        cyc(s, th, 1'b1, th, w);
        idle(s, N + 4);
        expect_drained(s, name);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " winner"},   32'(bus0.topic_winner),   0);
        chk({tag, " strength"}, 32'(bus0.topic_strength), 0);
        chk({tag, " valid"},    32'(bus0.topic_valid),    0);
        chk({tag, " changed"},  32'(bus0.topic_changed),  0);
        chk({tag, " busy"},     32'(bus0.busy),           0);
        chk({tag, " overrun"},  32'(bus0.overrun),        0);
    endtask

    initial begin
        bus0.theta_tick = 1'b0; bus0.delta_tick = 1'b0; bus0.ep_valid = 1'b0; bus0.ep_winner = '0;
        bus1.theta_tick = 1'b0; bus1.delta_tick = 1'b0; bus1.ep_valid = 1'b0; bus1.ep_winner = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        idle(0, 2);

        // Plain majority.
        votes(0, 3'd2, 4); votes(0, 3'd5, 1);
        close(0, 1'b0, '0, '{w: 3'd2, s: 3'd4, v: 1'b1, c: 1'b1, o: 1'b0}, "majority");

        // Below threshold: strength reported, winner held.
        votes(0, 3'd1, 1); votes(0, 3'd3, 1); votes(0, 3'd5, 1); votes(0, 3'd0, 1); votes(0, 3'd4, 1);
        close(0, 1'b0, '0, '{w: 3'd2, s: 3'd1, v: 1'b1, c: 1'b0, o: 1'b0}, "below_thr");

        // Tie at saturation resolves to the lower index.
        votes(0, 3'd4, 9); votes(0, 3'd1, 9);
        close(0, 1'b0, '0, '{w: 3'd1, s: 3'd7, v: 1'b1, c: 1'b1, o: 1'b0}, "tie_sat");

        // Theta coincident with delta lands in the closing window (2 -> 3 meets threshold).
        votes(0, 3'd3, 2);
        close(0, 1'b1, 3'd3, '{w: 3'd3, s: 3'd3, v: 1'b1, c: 1'b0 | 1'b1, o: 1'b0}, "theta_delta");

        // Out-of-range index and unqualified thetas take no vote.
        votes(0, 3'd7, 3);
        repeat (3) cyc(0, 1'b1, 1'b0, 1'b0, 3'd0);
        close(0, 1'b0, '0, '{w: 3'd3, s: 3'd0, v: 1'b1, c: 1'b0, o: 1'b0}, "invalid_idx");

        // Events while busy: first theta pended, second theta and delta overrun.
        q0.push_back('{w: 3'd3, s: 3'd0, v: 1'b1, c: 1'b0, o: 1'b1});
        cyc(0, 1'b0, 1'b1, 1'b0, '0);
        cyc(0, 1'b1, 1'b0, 1'b1, 3'd5);
        cyc(0, 1'b1, 1'b0, 1'b1, 3'd2);
        cyc(0, 1'b0, 1'b1, 1'b0, '0);
        idle(0, N + 2);
        expect_drained(0, "busy_events");
        close(0, 1'b0, '0, '{w: 3'd3, s: 3'd1, v: 1'b1, c: 1'b0, o: 1'b1}, "pending_applied");

        // Reset during SCAN aborts the window and clears everything.
        votes(0, 3'd4, 3);
        cyc(0, 1'b0, 1'b1, 1'b0, '0);
        idle(0, 2);
        rst_n = 1'b0;
        #2;
        chk_reset("mid_scan_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0, 1);
        votes(0, 3'd5, 3);
        close(0, 1'b0, '0, '{w: 3'd5, s: 3'd3, v: 1'b1, c: 1'b1, o: 1'b0}, "after_reset");

        // Leaky carry-over: 6 halves to 3, re-committed without a change pulse.
        votes(1, 3'd3, 6);
        close(1, 1'b0, '0, '{w: 3'd3, s: 3'd6, v: 1'b1, c: 1'b1, o: 1'b0}, "leak_w1");
        close(1, 1'b0, '0, '{w: 3'd3, s: 3'd3, v: 1'b1, c: 1'b0, o: 1'b0}, "leak_w2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1);
    end
endmodule
